rf_write_scheduler: RTL and testbench
=====================================

// Module: rf_write_scheduler
// PURPOSE
//  Shares the register-file write port between NUM_REQ requesters (e.g. switch loader, core writeback).
//  Uses round-robin arbitration with a req/ack handshake.
//  After writes it sequences the register renderer (start/done handshake, then re-arm reset) so the VGA view tracks RF contents.
//  Sits between the requesters and register_file / register_renderer in the top level.
// PARAMETERS
//  NUM_REQ         2      number of write requesters (1..4)
//  ADDR_W          5      register address width
//  DATA_W          32     register data width
//  MAX_BURST       4      max back-to-back writes before a pending render is forced
//  TIMEOUT_CYCLES  65536  render watchdog limit (used only with RF_SCHED_TIMEOUT_EN)
// PORTS
//  clk         in   1               system clock (CLOCK_50)
//  rst         in   1               async active-low reset
//  req         in   NUM_REQ         write request; held until ack
//  req_addr    in   NUM_REQ*ADDR_W  packed per-requester address, slice i = [i*ADDR_W +: ADDR_W]
//  req_data    in   NUM_REQ*DATA_W  packed per-requester data, slice i = [i*DATA_W +: DATA_W]
//  ack         out  NUM_REQ         one-cycle pulse; the write is accepted
//  rf_w_en     out  1               register file write enable
//  rf_w_addr   out  ADDR_W          register file write address
//  rf_w_data   out  DATA_W          register file write data
//  rr_start    out  1               renderer start; level, held until rr_done
//  rr_done     in   1               renderer finished
//  rr_rst_n    out  1               renderer reset, active-low = rst & rearm_n
//  busy        out  1               FSM not in IDLE
//  render_err  out  1               sticky watchdog error; constant 0 without the macro
// BEHAVIOUR
//  Reset: state IDLE. ack, rf_w_en, rf_w_addr, rf_w_data, rr_start, busy, render_err = 0.
//  Reset: rearm_n = 1, dirty = 0, burst_cnt = 0, rr_ptr = 0.
//  Reset mid-render: renderer is also held in reset via rr_rst_n; nothing is resumed.
//  States:
//   IDLE -> WRITE when any req and burst_cnt < MAX_BURST.
//   IDLE -> START when dirty and (no req or burst_cnt == MAX_BURST).
//   WRITE -> IDLE, unconditionally after 1 cycle.
//   START -> WAIT, after 1 cycle; rr_start is asserted on entry.
//   WAIT -> REARM on rr_done.
//   REARM -> IDLE, after 1 cycle.
//  Arbitration (IDLE): grant the first asserted req at index >= rr_ptr, wrapping modulo NUM_REQ.
//   Winner's addr/data are registered. rr_ptr <= grant + 1 (mod NUM_REQ).
//  WRITE: for exactly one cycle, ack[grant] = 1 and rf_w_en = 1 with the registered addr/data.
//   The requester sees ack at t+1 after req is sampled in IDLE at t.
//   It may re-request at t+2 at the earliest; a new req is sampled in IDLE.
//   Each write sets dirty and increments burst_cnt (saturating at MAX_BURST).
//  x0 guard: req_addr == 0 is still acked, but rf_w_en stays 0 and dirty is not set.
//  START entry: dirty <= 0, burst_cnt <= 0. rr_start = 1 through WAIT.
//   No writes are granted in START, WAIT or REARM; requests stall.
//  REARM: rr_start <= 0, rearm_n = 0 for one cycle (renderer FSM re-armed), then 1.
//  Simultaneous events:
//   rr_done with pending req: REARM first, then arbitration.
//   Req and dirty with burst_cnt < MAX_BURST: the write wins.
//  rr_done outside WAIT is ignored.
// CONFIGURATION
//  RF_SCHED_TIMEOUT_EN defined: a 17-bit counter runs in WAIT.
//   On reaching TIMEOUT_CYCLES without rr_done: go to REARM, set render_err (sticky until rst), set dirty again.
//  RF_SCHED_TIMEOUT_EN undefined: no counter; WAIT waits forever; render_err tied 0.
// STRUCTURE
//  rf_sched_pkg: state encoding (IDLE, WRITE, START, WAIT, REARM, 3-bit), ADDR_W/DATA_W defaults, X0_ADDR constant.
//  Sub-module rr_arbiter: combinational round-robin grant (req, ptr -> one-hot grant, valid).
//  FSM, registers and watchdog stay in this module.
// TESTING
//  1. Single write: req[0], addr 5, data 0x2A5.
//     -> ack[0] and rf_w_en for 1 cycle at t+1 with addr 5 / 0x2A5.
//     -> rr_start asserted 2 cycles later.
//  2. Contention: req[0] and req[1] held with rr_ptr = 0.
//     -> grants in order 0, 1; with both re-requesting, they alternate.
//     -> never two acks in the same cycle.
//  3. Burst: req[1] re-asserted continuously for 6 writes, MAX_BURST = 4.
//     -> render starts after the 4th write; the 5th ack follows REARM.
//  4. x0: req addr 0, data 0xFFFF_FFFF.
//     -> ack pulses, rf_w_en stays 0, no rr_start.
//  5. Render handshake: rr_done 10 cycles after start.
//     -> rr_start drops, rr_rst_n low exactly 1 cycle, busy drops the cycle after.
//  6. Reset mid-WAIT: rst low for 1 cycle.
//     -> all outputs 0, rr_rst_n 0 during reset, FSM in IDLE.
//     -> with the macro and TIMEOUT_CYCLES = 16 and no rr_done: render_err = 1 after 16 cycles.

Source files
------------

// File: rtl/rf_sched_pkg.sv
// Shared definitions for the register-file write scheduler.
//   sched_state_e : scheduler FSM encoding (3-bit)
//   ADDR_W_DEF / DATA_W_DEF : default register address / data widths
//   X0_ADDR       : hard-wired zero register; writes to it are acked but dropped
//   WD_W          : render watchdog counter width (RF_SCHED_TIMEOUT_EN builds)
//   wrap_add      : (a + b) mod n, used for round-robin pointer arithmetic
package rf_sched_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWrite = 3'd1,
        StStart = 3'd2,
        StWait  = 3'd3,
        StRearm = 3'd4
    } sched_state_e;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned X0_ADDR    = 0;
    localparam int unsigned WD_W       = 17;

    function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                             input int unsigned n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first asserted request at index >= ptr, wrapping modulo NUM_REQ.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  PTR_W    highest-priority index for this decision
//   grant out NUM_REQ  one-hot grant (all zero when valid is 0)
//   valid out 1        at least one request is asserted
module rr_arbiter
    import rf_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'(wrap_add(32'(ptr), i, NUM_REQ));
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// Register-file write port scheduler.
// Round-robin shares the RF write port among NUM_REQ requesters (req/ack handshake) and,
// once writes have landed, sequences the register renderer (start/done, then a one-cycle
// re-arm reset) so the VGA view tracks RF contents.
// Optional feature: define RF_SCHED_TIMEOUT_EN to add a render watchdog that aborts a
// stuck render after TIMEOUT_CYCLES, sets sticky render_err and re-queues the render.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   req        in   per-requester write request, held until ack
//   req_addr   in   packed addresses, slice i = [i*ADDR_W +: ADDR_W]
//   req_data   in   packed data, slice i = [i*DATA_W +: DATA_W]
//   ack        out  one-cycle accept pulse per requester
//   rf_w_en    out  register file write enable
//   rf_w_addr  out  register file write address
//   rf_w_data  out  register file write data
//   rr_start   out  renderer start level, held until rr_done
//   rr_done    in   renderer finished (honoured only while waiting)
//   rr_rst_n   out  renderer reset, active-low (rst & re-arm)
//   busy       out  scheduler not idle
//   render_err out  sticky watchdog error (0 without RF_SCHED_TIMEOUT_EN)
module rf_write_scheduler
    import rf_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned MAX_BURST      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      rf_w_en,
    output logic [ADDR_W-1:0]         rf_w_addr,
    output logic [DATA_W-1:0]         rf_w_data,
    output logic                      rr_start,
    input  logic                      rr_done,
    output logic                      rr_rst_n,
    output logic                      busy,
    output logic                      render_err
);

    localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

    if (NUM_REQ < 1 || NUM_REQ > 4 || MAX_BURST < 1 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_param_check
        $error("rf_write_scheduler: parameter out of range");
    end

    sched_state_e        state_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic                rf_w_en_q;
    logic [ADDR_W-1:0]   rf_w_addr_q;
    logic [DATA_W-1:0]   rf_w_data_q;
    logic                rr_start_q;
    logic                rearm_n_q;
    logic                dirty_q;
    logic [BURST_W-1:0]  burst_cnt_q;
    logic [PTR_W-1:0]    rr_ptr_q;

    logic [NUM_REQ-1:0]  grant;
    logic                grant_valid;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    next_ptr;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic                burst_full;
    logic                win_is_x0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req   (req),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .valid (grant_valid)
    );

    // Encode the one-hot grant and select the winner's address/data.
    always_comb begin
        grant_idx = '0;
        win_addr  = '0;
        win_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
                win_addr  = req_addr[i*ADDR_W +: ADDR_W];
                win_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign next_ptr   = PTR_W'(wrap_add(32'(grant_idx), 1, NUM_REQ));
    assign burst_full = (burst_cnt_q == BURST_W'(MAX_BURST));
    assign win_is_x0  = (win_addr == ADDR_W'(X0_ADDR));

`ifdef RF_SCHED_TIMEOUT_EN
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_cnt_q;
    logic            render_err_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            ack_q       <= '0;
            rf_w_en_q   <= 1'b0;
            rf_w_addr_q <= '0;
            rf_w_data_q <= '0;
            rr_start_q  <= 1'b0;
            rearm_n_q   <= 1'b1;
            dirty_q     <= 1'b0;
            burst_cnt_q <= '0;
            rr_ptr_q    <= '0;
`ifdef RF_SCHED_TIMEOUT_EN
            wd_cnt_q     <= '0;
            render_err_q <= 1'b0;
`endif
        end else begin
            // Write-side outputs are single-cycle pulses.
            ack_q     <= '0;
            rf_w_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A pending request beats a pending render until the burst limit.
                    if (grant_valid && !burst_full) begin
                        state_q     <= StWrite;
                        ack_q       <= grant;
                        rr_ptr_q    <= next_ptr;
                        rf_w_addr_q <= win_addr;
                        rf_w_data_q <= win_data;
                        // x0 writes are acked but never reach the RF; they also do not
                        // count toward the burst, so they cannot starve requesters.
                        if (!win_is_x0) begin
                            rf_w_en_q   <= 1'b1;
                            dirty_q     <= 1'b1;
                            burst_cnt_q <= burst_cnt_q + 1'b1;
                        end
                    end else if (dirty_q) begin
                        state_q     <= StStart;
                        rr_start_q  <= 1'b1;
                        dirty_q     <= 1'b0;
                        burst_cnt_q <= '0;
                    end
                end
                StWrite: state_q <= StIdle;
                StStart: state_q <= StWait;
                StWait: begin
                    if (rr_done) begin
                        state_q    <= StRearm;
                        rr_start_q <= 1'b0;
                        rearm_n_q  <= 1'b0;
                    end
`ifdef RF_SCHED_TIMEOUT_EN
                    else if (wd_cnt_q == WD_LIMIT) begin
                        // Abort the stuck render and queue another attempt.
                        state_q      <= StRearm;
                        rr_start_q   <= 1'b0;
                        rearm_n_q    <= 1'b0;
                        render_err_q <= 1'b1;
                        dirty_q      <= 1'b1;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
`endif
                end
                StRearm: begin
                    state_q   <= StIdle;
                    rearm_n_q <= 1'b1;
`ifdef RF_SCHED_TIMEOUT_EN
                    wd_cnt_q  <= '0;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ack       = ack_q;
    assign rf_w_en   = rf_w_en_q;
    assign rf_w_addr = rf_w_addr_q;
    assign rf_w_data = rf_w_data_q;
    assign rr_start  = rr_start_q;
    // Renderer is held in reset whenever the scheduler is, so nothing resumes mid-render.
    assign rr_rst_n  = rst & rearm_n_q;
    assign busy      = (state_q != StIdle);

`ifdef RF_SCHED_TIMEOUT_EN
    assign render_err = render_err_q;
`else
    assign render_err = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed self-checking bench for rf_write_scheduler (NUM_REQ=2, ADDR_W=5, DATA_W=32,
// MAX_BURST=4, TIMEOUT_CYCLES=16). Inputs are driven and outputs sampled on the falling edge.
module tb_rf_write_scheduler;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic [1:0]  ack;
    logic        rf_w_en;
    logic [4:0]  rf_w_addr;
    logic [31:0] rf_w_data;
    logic        rr_start;
    logic        rr_done;
    logic        rr_rst_n;
    logic        busy;
    logic        render_err;

    int n_checks = 0;
    int n_fail   = 0;

    rf_write_scheduler #(
        .NUM_REQ        (2),
        .ADDR_W         (5),
        .DATA_W         (32),
        .MAX_BURST      (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .ack        (ack),
        .rf_w_en    (rf_w_en),
        .rf_w_addr  (rf_w_addr),
        .rf_w_data  (rf_w_data),
        .rr_start   (rr_start),
        .rr_done    (rr_done),
        .rr_rst_n   (rr_rst_n),
        .busy       (busy),
        .render_err (render_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_req(input int idx, input logic [4:0] a, input logic [31:0] d);
        req[idx]               = 1'b1;
        req_addr[idx*5 +: 5]   = a;
        req_data[idx*32 +: 32] = d;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        rr_done  = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
    endtask

    // Complete any pending render: wait for rr_start, hold rr_done until it drops,
    // then wait for the scheduler to go idle. All waits bounded.
    task automatic finish_render(input string tag);
        int n;
        n = 0;
        while (!rr_start && n < 20) begin step(); n++; end
        check({tag, "_rr_start_seen"}, 64'(rr_start), 64'd1);
        rr_done = 1'b1;
        n = 0;
        while (rr_start && n < 20) begin step(); n++; end
        rr_done = 1'b0;
        check({tag, "_rr_start_dropped"}, 64'(rr_start), 64'd0);
        n = 0;
        while (busy && n < 20) begin step(); n++; end
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [1:0] exp_ack;
        logic [4:0] exp_addr;

        // Reset values, observed while rst is low.
        rst = 1'b0; req = '0; req_addr = '0; req_data = '0; rr_done = 1'b0;
        repeat (2) step();
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_rf_w_en", 64'(rf_w_en), 64'd0);
        check("rst_rf_w_addr", 64'(rf_w_addr), 64'd0);
        check("rst_rf_w_data", 64'(rf_w_data), 64'd0);
        check("rst_rr_start", 64'(rr_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_render_err", 64'(render_err), 64'd0);
        check("rst_rr_rst_n", 64'(rr_rst_n), 64'd0);
        rst = 1'b1;
        step();
        check("post_rst_rr_rst_n", 64'(rr_rst_n), 64'd1);

        // 1 + 5: single write, then render handshake with rr_done 10 cycles after start.
        set_req(0, 5'd5, 32'h2A5);
        step();                                              // t+1: WRITE
        check("t1_ack", 64'(ack), 64'd1);
        check("t1_rf_w_en", 64'(rf_w_en), 64'd1);
        check("t1_rf_w_addr", 64'(rf_w_addr), 64'd5);
        check("t1_rf_w_data", 64'(rf_w_data), 64'h2A5);
        check("t1_busy", 64'(busy), 64'd1);
        req = '0;
        step();                                              // t+2: IDLE
        check("t1_ack_pulse", 64'(ack), 64'd0);
        check("t1_rf_w_en_pulse", 64'(rf_w_en), 64'd0);
        check("t1_rr_start_early", 64'(rr_start), 64'd0);
        step();                                              // t+3: START
        check("t1_rr_start", 64'(rr_start), 64'd1);
        for (int c = 1; c <= 9; c++) begin
            step();
            check("t5_rr_start_held", 64'(rr_start), 64'd1);
            check("t5_busy_held", 64'(busy), 64'd1);
        end
        rr_done = 1'b1;                                      // 10 cycles after start
        step();                                              // REARM
        rr_done = 1'b0;
        check("t5_rr_start_drop", 64'(rr_start), 64'd0);
        check("t5_rr_rst_n_low", 64'(rr_rst_n), 64'd0);
        check("t5_busy_rearm", 64'(busy), 64'd1);
        step();                                              // IDLE
        check("t5_rr_rst_n_high", 64'(rr_rst_n), 64'd1);
        check("t5_busy_drop", 64'(busy), 64'd0);

        // 2: contention from rr_ptr = 0; grants 0,1,0,1 then burst limit forces a render.
        do_reset();
        set_req(0, 5'd1, 32'h1111);
        set_req(1, 5'd2, 32'h2222);
        for (int c = 1; c <= 9; c++) begin
            step();
            exp_ack  = (c == 1 || c == 5) ? 2'b01 : (c == 3 || c == 7) ? 2'b10 : 2'b00;
            exp_addr = (c == 1 || c == 5) ? 5'd1 : 5'd2;
            check($sformatf("t2_ack_c%0d", c), 64'(ack), 64'(exp_ack));
            check($sformatf("t2_onehot_c%0d", c), 64'($countones(ack) > 1), 64'd0);
            if (exp_ack != 2'b00)
                check($sformatf("t2_addr_c%0d", c), 64'(rf_w_addr), 64'(exp_addr));
            if (c == 8) req = '0;
        end
        check("t2_rr_start", 64'(rr_start), 64'd1);
        finish_render("t2");

        // 3: requester 1 re-requests for 6 writes; render after the 4th, 5th ack after REARM.
        do_reset();
        set_req(1, 5'd3, 32'hB0B0);
        for (int c = 1; c <= 15; c++) begin
            step();
            exp_ack = (c inside {1, 3, 5, 7, 13, 15}) ? 2'b10 : 2'b00;
            check($sformatf("t3_ack_c%0d", c), 64'(ack), 64'(exp_ack));
            check($sformatf("t3_rr_start_c%0d", c), 64'(rr_start),
                  64'(c == 9 || c == 10));
            rr_done = (c == 10);
            if (c == 11) check("t3_rearm", 64'(rr_rst_n), 64'd0);
            if (c == 15) req = '0;
        end
        finish_render("t3");

        // 4: x0 write is acked but not written and does not trigger a render.
        do_reset();
        set_req(0, 5'd0, 32'hFFFF_FFFF);
        step();
        check("t4_ack", 64'(ack), 64'd1);
        check("t4_rf_w_en", 64'(rf_w_en), 64'd0);
        req = '0;
        repeat (3) begin
            step();
            check("t4_no_rr_start", 64'(rr_start), 64'd0);
            check("t4_idle", 64'(busy), 64'd0);
        end

        // 6: reset mid-WAIT clears everything; nothing resumes afterwards.
        do_reset();
        set_req(0, 5'd7, 32'h77);
        step();
        req = '0;
        repeat (5) step();                                   // in WAIT
        check("t6_in_wait", 64'(rr_start), 64'd1);
        rst = 1'b0;
        #1;
        check("t6_rst_ack", 64'(ack), 64'd0);
        check("t6_rst_rf_w_addr", 64'(rf_w_addr), 64'd0);
        check("t6_rst_rf_w_data", 64'(rf_w_data), 64'd0);
        check("t6_rst_rr_start", 64'(rr_start), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_rr_rst_n", 64'(rr_rst_n), 64'd0);
        step();
        rst = 1'b1;
        repeat (3) begin
            step();
            check("t6_after_rr_start", 64'(rr_start), 64'd0);
            check("t6_after_busy", 64'(busy), 64'd0);
            check("t6_after_rr_rst_n", 64'(rr_rst_n), 64'd1);
        end

        // Watchdog: no rr_done; WAIT spans cycles 4..19.
        do_reset();
        set_req(0, 5'd9, 32'h99);
        for (int c = 1; c <= 24; c++) begin
            step();
            if (c == 1) req = '0;
`ifdef RF_SCHED_TIMEOUT_EN
            if (c == 19) check("wd_err_before", 64'(render_err), 64'd0);
            if (c == 20) begin
                check("wd_err_set", 64'(render_err), 64'd1);
                check("wd_rearm", 64'(rr_rst_n), 64'd0);
                check("wd_start_drop", 64'(rr_start), 64'd0);
            end
            if (c == 22) check("wd_restart", 64'(rr_start), 64'd1);
            if (c == 24) check("wd_err_sticky", 64'(render_err), 64'd1);
`else
            if (c == 24) begin
                check("nowd_waiting", 64'(rr_start), 64'd1);
                check("nowd_err", 64'(render_err), 64'd0);
            end
`endif
        end
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
